rssb_sequencer: RTL and testbench

Multi-cycle controller FSM that sequences the RSSB datapath (PC, OP1 and ACC registers, subtractor, shared data memory) through fetch / execute / acc-load / pc-update for each instruction. It adds run, single-step and halt-request control, halt-address detection and a retired-instruction counter. It drives the datapath's select and write-enable strobes and sits between the datapath and the testbench/debug host.

---
 rtl/rssb_sequencer.sv | 149 ++++++++++++++
 tb/tb_rssb_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rssb_sequencer.sv
// rssb_sequencer: multi-cycle control FSM for the RSSB datapath.
// Walks each instruction through FETCH, EXEC, LOAD and UPDATE, driving the
// datapath select and write strobes. Also provides run / single-step /
// halt-request control, halt-address detection and a retired-instruction
// counter.
module rssb_sequencer #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   HALT_ADDR = 8'hFF,
    parameter int                 CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             halt_req,
    input  logic             neg,
    input  logic [WIDTH-1:0] mem_rd,
    output logic             sel_pc,
    output logic             sel_mem,
    output logic             write_op1,
    output logic             write_mem,
    output logic             write_acc,
    output logic             write_pc,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] LOAD   = 3'd3;
    localparam logic [2:0] UPDATE = 3'd4;
    localparam logic [2:0] HALTED = 3'd5;

    logic [2:0]       state_q, state_d;
    logic             neg_q, neg_d;
    logic             halt_pend_q, halt_pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state logic: instructions are atomic, so run and halt requests
    // are only acted on at the UPDATE boundary.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (run || step) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (mem_rd == HALT_ADDR) begin
                    state_d = HALTED;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC:   state_d = LOAD;
            LOAD:   state_d = UPDATE;
            UPDATE: begin
                if (halt_req || halt_pend_q || !run) begin
                    state_d = IDLE;
                end else begin
                    state_d = FETCH;
                end
            end
            HALTED: state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    // Borrow capture, halt-request latch and saturating retire counter.
    // A one-cycle halt_req pulse seen mid-instruction is held until UPDATE.
    always_comb begin
        neg_d       = neg_q;
        halt_pend_d = halt_pend_q;
        cnt_d       = cnt_q;
        if (state_q == EXEC) begin
            neg_d = neg;
        end
        if (state_q == UPDATE) begin
            halt_pend_d = 1'b0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if ((state_q == FETCH || state_q == EXEC || state_q == LOAD)
                     && halt_req) begin
            halt_pend_d = 1'b1;
        end
    end

    // State and control registers; the active-low reset aborts any
    // in-flight instruction immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            neg_q       <= 1'b0;
            halt_pend_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            neg_q       <= neg_d;
            halt_pend_q <= halt_pend_d;
            cnt_q       <= cnt_d;
        end
    end

    // Moore output decode; at most one write strobe is active per state.
    always_comb begin
        sel_pc    = 1'b0;
        sel_mem   = 1'b0;
        write_op1 = 1'b0;
        write_mem = 1'b0;
        write_acc = 1'b0;
        write_pc  = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        case (state_q)
            FETCH: begin
                write_op1 = 1'b1;
                busy      = 1'b1;
            end
            EXEC: begin
                sel_mem   = 1'b1;
                write_mem = 1'b1;
                busy      = 1'b1;
            end
            LOAD: begin
                sel_mem   = 1'b1;
                write_acc = 1'b1;
                busy      = 1'b1;
            end
            UPDATE: begin
                write_pc = 1'b1;
                sel_pc   = neg_q;
                busy     = 1'b1;
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign instr_count = cnt_q;

endmodule

// File: tb/tb_rssb_sequencer.sv
// tb_rssb_sequencer: directed self-checking bench for rssb_sequencer.
// A small behavioural RSSB datapath (PC, OP1, ACC, 256-byte memory) reacts
// to the sequencer strobes so that memory, ACC and PC results can be checked
// against hand-computed values.
module tb_rssb_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic        step;
    logic        haltReq;
    logic        dpNeg;
    logic [7:0]  memRd;
    logic        sel_pc;
    logic        sel_mem;
    logic        write_op1;
    logic        write_mem;
    logic        write_acc;
    logic        write_pc;
    logic        busy;
    logic        halted;
    logic [15:0] instrCount;

    int testsRun  = 0;
    int failCount = 0;

    logic [7:0]  mem [256];
    logic [7:0]  pc;
    logic [7:0]  op1;
    logic [7:0]  acc;
    logic [7:0]  dpAddr;
    logic [7:0]  dpDiff;
    logic [31:0] dpWrites;

    logic        preset;
    logic [7:0]  presetPc;
    logic [7:0]  presetAcc;
    logic [7:0]  presetAddr [4];
    logic [7:0]  presetData [4];

    rssb_sequencer #(
        .WIDTH    (8),
        .HALT_ADDR(8'hFF),
        .CNT_W    (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .step       (step),
        .halt_req   (haltReq),
        .neg        (dpNeg),
        .mem_rd     (memRd),
        .sel_pc     (sel_pc),
        .sel_mem    (sel_mem),
        .write_op1  (write_op1),
        .write_mem  (write_mem),
        .write_acc  (write_acc),
        .write_pc   (write_pc),
        .busy       (busy),
        .halted     (halted),
        .instr_count(instrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dpAddr = sel_mem ? op1 : pc;
    assign memRd  = mem[dpAddr];
    assign dpDiff = memRd - acc;
    assign dpNeg  = (memRd < acc);

    // Behavioural datapath: registers update on the strobes, or are
    // preloaded from the bench while the sequencer sits idle.
    always @(posedge clk) begin
        if (preset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            for (int j = 0; j < 4; j++) mem[presetAddr[j]] <= presetData[j];
            pc       <= presetPc;
            acc      <= presetAcc;
            op1      <= 8'h00;
            dpWrites <= 32'd0;
        end else begin
            if (write_op1) op1 <= memRd;
            if (write_mem) mem[dpAddr] <= dpDiff;
            if (write_acc) acc <= memRd;
            if (write_pc)  pc <= sel_pc ? pc + 8'd2 : pc + 8'd1;
            if (write_mem || write_acc || write_pc) dpWrites <= dpWrites + 32'd1;
        end
    end

    // One comparison: counts it, and reports tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive the control inputs and advance to the next falling edge.
    task automatic applyStimulus(input logic r, input logic s, input logic h);
        run     = r;
        step    = s;
        haltReq = h;
        @(negedge clk);
    endtask

    // Load PC, ACC and up to four memory words into the model datapath.
    task automatic presetDp(input logic [7:0] pcVal, input logic [7:0] accVal,
                            input logic [7:0] a0, input logic [7:0] d0,
                            input logic [7:0] a1, input logic [7:0] d1,
                            input logic [7:0] a2, input logic [7:0] d2,
                            input logic [7:0] a3, input logic [7:0] d3);
        presetPc      = pcVal;
        presetAcc     = accVal;
        presetAddr[0] = a0; presetData[0] = d0;
        presetAddr[1] = a1; presetData[1] = d1;
        presetAddr[2] = a2; presetData[2] = d2;
        presetAddr[3] = a3; presetData[3] = d3;
        preset = 1'b1;
        @(negedge clk);
        preset = 1'b0;
    endtask

    function automatic logic [31:0] strobes();
        return {26'd0, sel_pc, sel_mem, write_op1, write_mem, write_acc, write_pc};
    endfunction

    // Directed sequence following the RSSB sequencer test plan.
    initial begin
        rst = 1'b0; run = 1'b1; step = 1'b0; haltReq = 1'b0; preset = 1'b0;
        presetPc = 8'h00; presetAcc = 8'h00;
        for (int k = 0; k < 4; k++) begin
            presetAddr[k] = 8'h80;
            presetData[k] = 8'h00;
        end

        // Reset held with run high.
        presetDp(8'h00, 8'h00, 8'h00, 8'h05, 8'h05, 8'h03, 8'h80, 8'h00, 8'h80, 8'h00);
        repeat (3) @(negedge clk);
        checkOutput("rst_strobes", strobes(), 32'h0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_halted", {31'd0, halted}, 32'd0);
        checkOutput("rst_count", {16'd0, instrCount}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rel_fetch_op1", {31'd0, write_op1}, 32'd1);
        checkOutput("rel_fetch_busy", {31'd0, busy}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("rel_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("rel_count", {16'd0, instrCount}, 32'd1);

        // Single step, non-negative result: 3 - 0 = 3.
        presetDp(8'h00, 8'h00, 8'h00, 8'h05, 8'h05, 8'h03, 8'h80, 8'h00, 8'h80, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0);
        step = 1'b0;
        checkOutput("s1_fetch", strobes(), 32'b001000);
        @(negedge clk);
        checkOutput("s1_exec", strobes(), 32'b010100);
        @(negedge clk);
        checkOutput("s1_load", strobes(), 32'b010010);
        @(negedge clk);
        checkOutput("s1_update", strobes(), 32'b000001);
        @(negedge clk);
        checkOutput("s1_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("s1_count", {16'd0, instrCount}, 32'd2);
        checkOutput("s1_mem5", {24'd0, mem[5]}, 32'h03);
        checkOutput("s1_acc", {24'd0, acc}, 32'h03);
        checkOutput("s1_pc", {24'd0, pc}, 32'h01);

        // Single step, negative result: 3 - 7 = 0xFC, skip taken.
        presetDp(8'h00, 8'h07, 8'h00, 8'h05, 8'h05, 8'h03, 8'h80, 8'h00, 8'h80, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0);
        step = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("s2_update", strobes(), 32'b100001);
        @(negedge clk);
        checkOutput("s2_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("s2_mem5", {24'd0, mem[5]}, 32'hFC);
        checkOutput("s2_acc", {24'd0, acc}, 32'hFC);
        checkOutput("s2_pc", {24'd0, pc}, 32'h02);
        checkOutput("s2_count", {16'd0, instrCount}, 32'd3);

        // halt_req pulse during EXEC of the second instruction.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        presetDp(8'h00, 8'h00, 8'h00, 8'h05, 8'h05, 8'h03, 8'h01, 8'h06, 8'h06, 8'h0A);
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("hr_fetch2", strobes(), 32'b001000);
        checkOutput("hr_count1", {16'd0, instrCount}, 32'd1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b1);
        haltReq = 1'b0;
        checkOutput("hr_load2", strobes(), 32'b010010);
        @(negedge clk);
        checkOutput("hr_update2", strobes(), 32'b000001);
        @(negedge clk);
        run = 1'b0;
        checkOutput("hr_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("hr_count2", {16'd0, instrCount}, 32'd2);
        @(negedge clk);
        checkOutput("hr_stays_idle", {31'd0, busy}, 32'd0);
        checkOutput("hr_mem6", {24'd0, mem[6]}, 32'h07);
        checkOutput("hr_acc", {24'd0, acc}, 32'h07);
        checkOutput("hr_pc", {24'd0, pc}, 32'h02);

        // Halt address fetched: machine stops and stays stopped.
        presetDp(8'h03, 8'h01, 8'h03, 8'hFF, 8'h80, 8'h00, 8'h80, 8'h00, 8'h80, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("ha_fetch", strobes(), 32'b001000);
        checkOutput("ha_fetch_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        checkOutput("ha_halted", {31'd0, halted}, 32'd1);
        checkOutput("ha_busy", {31'd0, busy}, 32'd0);
        checkOutput("ha_strobes", strobes(), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        run = 1'b0;
        checkOutput("ha_sticky", {31'd0, halted}, 32'd1);
        checkOutput("ha_sticky_busy", {31'd0, busy}, 32'd0);
        checkOutput("ha_pc", {24'd0, pc}, 32'h03);
        checkOutput("ha_acc", {24'd0, acc}, 32'h01);
        checkOutput("ha_no_writes", dpWrites, 32'd0);
        checkOutput("ha_count", {16'd0, instrCount}, 32'd2);

        // Asynchronous reset in the middle of EXEC.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checkOutput("ar_unhalt", {31'd0, halted}, 32'd0);
        presetDp(8'h00, 8'h00, 8'h00, 8'h05, 8'h05, 8'h03, 8'h80, 8'h00, 8'h80, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("ar_exec2", strobes(), 32'b010100);
        checkOutput("ar_count_pre", {16'd0, instrCount}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("ar_write_mem", {31'd0, write_mem}, 32'd0);
        checkOutput("ar_busy", {31'd0, busy}, 32'd0);
        checkOutput("ar_halted", {31'd0, halted}, 32'd0);
        checkOutput("ar_count", {16'd0, instrCount}, 32'd0);
        run = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("ar_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
